write_port_arbiter: RTL and testbench

WRITE_PORT_ARBITER -- requirements
Module: write_port_arbiter

---
 rtl/write_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_write_port_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/write_port_arbiter.sv
// ---------------------------------------------------------------------------
// write_port_arbiter
//
// Shares a single write port among NREQ requesters. A requester is picked
// round-robin in IDLE, then owns the port in GRANT for up to MAX_BURST
// transfers or until it drops its request. Every output is registered, and
// write data appears one cycle after the transfer that produced it.
//
// Parameters:
//   NREQ       number of requesters
//   DW         write data width
//   MAX_BURST  maximum transfers per grant (1..15)
//
// Ports:
//   clk           clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   req           per-requester request, held high while data is pending
//   req_data      flattened per-requester data, slice i = [i*DW +: DW]
//   gnt           registered one-hot-or-zero grant
//   write_enable  registered write strobe to the shared port
//   writedata     registered write data, all-zeros when write_enable = 0
//   busy          high while the FSM is in GRANT
//
// Optional build macro:
//   WRITE_PORT_ARBITER_XCHK_EN  adds X-propagation / protocol assertions
// ---------------------------------------------------------------------------
module write_port_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 write_enable,
    output logic [DW-1:0]        writedata,
    output logic                 busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state, state_next;
    logic [IW-1:0]     ptr, ptr_next;
    logic [IW-1:0]     owner, owner_next, owner_inc;
    logic [IW-1:0]     winner;
    logic [3:0]        cnt, cnt_next;
    logic [NREQ-1:0]   gnt_next;
    logic              we_next;
    logic [DW-1:0]     wd_next;
    logic [DW-1:0]     owner_data;
    logic              transfer;

    // Rotate the request vector so that bit 0 corresponds to ptr, take the
    // lowest set bit, then translate the offset back to a requester index.
    always_comb begin
        logic [2*NREQ-1:0] shifted;
        logic [NREQ-1:0]   rotated;
        logic              found;
        int                sum;
        shifted = {req, req} >> ptr;
        rotated = shifted[NREQ-1:0];
        found   = 1'b0;
        winner  = ptr;
        sum     = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && rotated[i]) begin
                found = 1'b1;
                sum   = int'(ptr) + i;
                if (sum >= NREQ) begin
                    sum = sum - NREQ;
                end
                winner = IW'(sum);
            end
        end
    end

    // Masking with gnt keeps non-owner req/req_data out of the datapath, so
    // X or Z on those inputs can never reach writedata.
    assign transfer = (state == GRANT) && |(gnt & req);

    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                owner_data = req_data[i*DW +: DW];
            end
        end
    end

    assign owner_inc = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        we_next    = 1'b0;
        wd_next    = '0;
        ptr_next   = ptr;
        cnt_next   = cnt;
        owner_next = owner;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_next = GRANT;
                    gnt_next   = NREQ'(1) << winner;
                    owner_next = winner;
                    cnt_next   = '0;
                end else begin
                    gnt_next = '0;
                end
            end
            GRANT: begin
                if (transfer) begin
                    we_next  = 1'b1;
                    wd_next  = owner_data;
                    cnt_next = cnt + 4'd1;
                    if (cnt == 4'(MAX_BURST - 1)) begin
                        state_next = IDLE;
                        gnt_next   = '0;
                        ptr_next   = owner_inc;
                    end
                end else begin
                    // Owner released the port early; no transfer this cycle.
                    state_next = IDLE;
                    gnt_next   = '0;
                    ptr_next   = owner_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            gnt          <= '0;
            write_enable <= 1'b0;
            writedata    <= '0;
            ptr          <= '0;
            cnt          <= '0;
            owner        <= '0;
        end else begin
            state        <= state_next;
            gnt          <= gnt_next;
            write_enable <= we_next;
            writedata    <= wd_next;
            ptr          <= ptr_next;
            cnt          <= cnt_next;
            owner        <= owner_next;
        end
    end

    assign busy = (state == GRANT);

`ifdef WRITE_PORT_ARBITER_XCHK_EN
    a_wd_known: assert property (@(posedge clk) disable iff (rst)
        !write_enable |-> !$isunknown(writedata))
        else $error("write_port_arbiter: writedata unknown while idle");

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(gnt))
        else $error("write_port_arbiter: gnt has more than one bit set");

    a_we_from_xfer: assert property (@(posedge clk) disable iff (rst)
        write_enable |-> $past(transfer))
        else $error("write_port_arbiter: write_enable without owner transfer");
`else
    // Checker-free build: identical ports and cycle behaviour.
`endif

endmodule

// File: tb/tb_write_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_write_port_arbiter
//
// Directed, table-driven bench for write_port_arbiter (NREQ=4, DW=8,
// MAX_BURST=4). Each record holds the inputs driven before a rising edge and
// the outputs expected just after it. Reset-mid-burst and X-isolation are
// written out as explicit sequences.
// ---------------------------------------------------------------------------
module tb_write_port_arbiter;

    localparam int NREQ      = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic              write_enable;
    logic [DW-1:0]     writedata;
    logic              busy;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    write_port_arbiter #(
        .NREQ      (NREQ),
        .DW        (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .gnt          (gnt),
        .write_enable (write_enable),
        .writedata    (writedata),
        .busy         (busy)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_gnt;
        logic        exp_we;
        logic [7:0]  exp_wd;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(string name, logic r, logic [3:0] rq,
                                    logic [31:0] d, logic [3:0] eg,
                                    logic ewe, logic [7:0] ewd, logic eb);
        vec_t v;
        v.name     = name;
        v.rst      = r;
        v.req      = rq;
        v.data     = d;
        v.exp_gnt  = eg;
        v.exp_we   = ewe;
        v.exp_wd   = ewd;
        v.exp_busy = eb;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic r, input logic [3:0] rq,
                                 input logic [31:0] d);
        @(negedge clk);
        rst      = r;
        req      = rq;
        req_data = d;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] eg,
                               input logic ewe, input logic [7:0] ewd,
                               input logic eb);
        tests_run++;
        if (gnt !== eg || write_enable !== ewe || writedata !== ewd || busy !== eb) begin
            tests_failed++;
            $display("[TB] FAIL %s: got gnt=%b we=%b wd=%h busy=%b, expected gnt=%b we=%b wd=%h busy=%b",
                     name, gnt, write_enable, writedata, busy, eg, ewe, ewd, eb);
        end
    endtask

    task automatic step(input string name, input logic r, input logic [3:0] rq,
                        input logic [31:0] d, input logic [3:0] eg,
                        input logic ewe, input logic [7:0] ewd, input logic eb);
        applyStimulus(r, rq, d);
        @(posedge clk);
        #1;
        checkOutput(name, eg, ewe, ewd, eb);
    endtask

    initial begin
        int          rr_order[5];
        logic [7:0]  rr_bytes[4];
        logic [31:0] x_data;
        logic [3:0]  x_req;

        rst      = 1'b1;
        req      = '0;
        req_data = '0;

        // Reset held two cycles with every requester asking.
        add_vec("rst_hold0", 1'b1, 4'b1111, 32'hFFFF_FFFF, 4'b0000, 1'b0, 8'h00, 1'b0);
        add_vec("rst_hold1", 1'b1, 4'b1111, 32'hFFFF_FFFF, 4'b0000, 1'b0, 8'h00, 1'b0);

        // Single requester: 4 writes of A5, one idle cycle, then regrant.
        add_vec("burst_arb", 1'b0, 4'b0001, 32'h0000_00A5, 4'b0001, 1'b0, 8'h00, 1'b1);
        for (int b = 0; b < MAX_BURST - 1; b++)
            add_vec("burst_beat", 1'b0, 4'b0001, 32'h0000_00A5, 4'b0001, 1'b1, 8'hA5, 1'b1);
        add_vec("burst_last", 1'b0, 4'b0001, 32'h0000_00A5, 4'b0000, 1'b1, 8'hA5, 1'b0);
        add_vec("burst_regrant", 1'b0, 4'b0001, 32'h0000_00A5, 4'b0001, 1'b0, 8'h00, 1'b1);
        add_vec("burst_drop", 1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 1'b0);
        add_vec("rst_rr", 1'b1, 4'b0000, 32'h0, 4'b0000, 1'b0, 8'h00, 1'b0);

        // All requesters held: grants 0,1,2,3,0 with 4 writes each.
        rr_order = '{0, 1, 2, 3, 0};
        rr_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int g = 0; g < 4; g++) begin
            add_vec("rr_arb", 1'b0, 4'b1111, 32'h4433_2211,
                    4'(1) << rr_order[g], 1'b0, 8'h00, 1'b1);
            for (int b = 0; b < MAX_BURST - 1; b++)
                add_vec("rr_beat", 1'b0, 4'b1111, 32'h4433_2211,
                        4'(1) << rr_order[g], 1'b1, rr_bytes[rr_order[g]], 1'b1);
            add_vec("rr_last", 1'b0, 4'b1111, 32'h4433_2211,
                    4'b0000, 1'b1, rr_bytes[rr_order[g]], 1'b0);
        end
        add_vec("rr_wrap", 1'b0, 4'b1111, 32'h4433_2211, 4'b0001, 1'b0, 8'h00, 1'b1);
        add_vec("rst_er", 1'b1, 4'b0000, 32'h0, 4'b0000, 1'b0, 8'h00, 1'b0);

        // Owner 2 releases after two writes; pointer then moves to 3.
        add_vec("er_arb", 1'b0, 4'b0100, 32'h0000_0000, 4'b0100, 1'b0, 8'h00, 1'b1);
        add_vec("er_beat1", 1'b0, 4'b0100, 32'h0011_0000, 4'b0100, 1'b1, 8'h11, 1'b1);
        add_vec("er_beat2", 1'b0, 4'b0100, 32'h0022_0000, 4'b0100, 1'b1, 8'h22, 1'b1);
        add_vec("er_release", 1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 1'b0);
        add_vec("er_idle", 1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 1'b0);
        add_vec("er_ptr3", 1'b0, 4'b1001, 32'h0000_0000, 4'b1000, 1'b0, 8'h00, 1'b1);

        // Reset clears the pointer back to 0.
        add_vec("rst_ptr", 1'b1, 4'b1001, 32'h0, 4'b0000, 1'b0, 8'h00, 1'b0);
        add_vec("ptr_zero", 1'b0, 4'b1001, 32'h0, 4'b0001, 1'b0, 8'h00, 1'b1);
        add_vec("ptr_drop", 1'b0, 4'b0000, 32'h0, 4'b0000, 1'b0, 8'h00, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].name, vecs[i].rst, vecs[i].req, vecs[i].data,
                 vecs[i].exp_gnt, vecs[i].exp_we, vecs[i].exp_wd, vecs[i].exp_busy);
        end

        // Reset pulsed on owner 1's second beat discards that beat.
        step("mid_arb",     1'b0, 4'b0010, 32'h0000_AA00, 4'b0010, 1'b0, 8'h00, 1'b1);
        step("mid_beat1",   1'b0, 4'b0010, 32'h0000_AA00, 4'b0010, 1'b1, 8'hAA, 1'b1);
        step("mid_rst",     1'b1, 4'b0010, 32'h0000_BB00, 4'b0000, 1'b0, 8'h00, 1'b0);
        step("mid_restart", 1'b0, 4'b0011, 32'h0000_CC77, 4'b0001, 1'b0, 8'h00, 1'b1);
        step("mid_beat",    1'b0, 4'b0011, 32'h0000_CC77, 4'b0001, 1'b1, 8'h77, 1'b1);
        step("rst_x",       1'b1, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 1'b0);

        // Non-owner req/data carry X and Z while owner 0 writes 3C.
        x_data = {8'hzz, 8'hxx, 8'hzz, 8'h3C};
        x_req  = 4'bxzx1;
        step("x_arb", 1'b0, 4'b0001, x_data, 4'b0001, 1'b0, 8'h00, 1'b1);
        for (int b = 0; b < MAX_BURST - 1; b++)
            step("x_beat", 1'b0, x_req, x_data, 4'b0001, 1'b1, 8'h3C, 1'b1);
        step("x_last", 1'b0, x_req, x_data, 4'b0000, 1'b1, 8'h3C, 1'b0);
        step("x_idle", 1'b0, 4'b0000, 32'hxxxx_xxxx, 4'b0000, 1'b0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
